// File: rtl/float_offset_detector_if.sv
// Sample stream into the block-floating-point exponent detector and its offset
// result. Parameters must match the attached float_offset_detector instance.
interface float_offset_detector_if #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 10
);
    localparam int OFSW = $clog2(IWIDTH - OWIDTH + 1);

    logic              i_sync;
    logic              i_freeze;
    logic              i_valid;
    logic [IWIDTH-1:0] i_data;
    logic [OFSW-1:0]   o_offset;
    logic              o_update;
    logic              o_first;

    modport master (
        output i_sync, i_freeze, i_valid, i_data,
        input  o_offset, o_update, o_first
    );

    modport slave (
        input  i_sync, i_freeze, i_valid, i_data,
        output o_offset, o_update, o_first
    );
endinterface

// File: rtl/float_offset_detector.sv
// Finds the redundant leading bits shared by a block of samples and turns them into
// the float_rounder MSB offset; the offset found in one block is applied to the next.
module float_offset_detector #(
    parameter int IWIDTH   = 16,
    parameter int OWIDTH   = 10,
    parameter     SIGNREP  = "SIGNED",
    parameter int BLOCKLEN = 64,
    parameter int GUARD    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkena,
    float_offset_detector_if.slave   bus
);
    localparam bit IS_SIGNED = (SIGNREP == "SIGNED");
    localparam int MAXOFS    = IWIDTH - OWIDTH;
    localparam int OFSW      = $clog2(MAXOFS + 1);
    localparam int CW        = $clog2(BLOCKLEN);
    // Signed samples drop the sign bit: a redundant sign bit XORs to zero.
    localparam int AW        = IS_SIGNED ? IWIDTH - 1 : IWIDTH;

    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   term;
    logic [AW-1:0]   scan;
    logic [OFSW-1:0] next_offset;
    logic            accept;
    logic            last;
    int              lz;
    int              raw;
    int              clamped;

    generate
        if (IS_SIGNED) begin : g_signed
            assign term = bus.i_data[IWIDTH-2:0] ^ {(IWIDTH-1){bus.i_data[IWIDTH-1]}};
        end else begin : g_unsigned
            assign term = bus.i_data;
        end
    endgenerate

    assign accept = bus.i_valid;
    assign last   = (cnt == CW'(BLOCKLEN - 1));
    assign scan   = acc | term;

    // NOTE: every variable driven here gets a value before any branch or loop can
    // skip it, so no latch is inferred.
    always_comb begin
        lz = AW;
        for (int i = 0; i < AW; i++) begin
            if (scan[i]) lz = AW - 1 - i;
        end
        raw         = (lz > GUARD) ? lz - GUARD : 0;
        clamped     = (raw > MAXOFS) ? MAXOFS : raw;
        next_offset = OFSW'(clamped);
    end

    // NOTE: sequential state uses non-blocking assignments only, and the reset is
    // sampled on the clock edge, taking priority over clkena.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            acc          <= '0;
            bus.o_offset <= '0;
            bus.o_update <= 1'b0;
            bus.o_first  <= 1'b0;
        end else if (clkena) begin
            bus.o_update <= 1'b0;
            bus.o_first  <= 1'b0;
            if (bus.i_sync) begin
                // Partial block is dropped; a coincident sample opens the new block.
                acc         <= accept ? term : '0;
                cnt         <= accept ? CW'(1) : '0;
                bus.o_first <= accept;
            end else if (accept) begin
                bus.o_first <= (cnt == '0);
                if (last) begin
                    acc          <= '0;
                    cnt          <= '0;
                    bus.o_update <= ~bus.i_freeze;
                    if (!bus.i_freeze) bus.o_offset <= next_offset;
                end else begin
                    acc <= acc | term;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
